csr_tohost_unit: RTL and testbench
==================================

Name: csr_tohost_unit

Overview:
- CPU-side CSR unit that executes Zicsr instructions on the tohost register (0x51e) and the read-only cycle/instret counters.
- Its tohost output is the register the ISA bench polls for pass/fail: bit0 = done, bits[31:1] = failing test number (0 = pass).
- Sits in the execute stage of Riscv151.
- Adds a RUN/HALT state machine so that the core's architectural counters freeze once a test reports done.

Parameters:
- TOHOST_ADDR, 12'h51e, CSR address of tohost.
- RESET_TOHOST, 32'h0000_0000, tohost value after reset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- csr_valid  in  1  a CSR instruction is in execute.
- stall  in  1  pipeline stall; the instruction does not commit this cycle.
- flush  in  1  the instruction is killed; no commit.
- csr_funct3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI.
- csr_addr  in  12  CSR address.
- csr_rs1_idx  in  5  rs1 field (the zimm field for the I-forms).
- csr_rs1_data  in  32  rs1 register value.
- inst_retire  in  1  one instruction retired this cycle.
- csr_rdata  out  32  old CSR value returned to rd.
- tohost  out  32  tohost register.
- halted  out  1  state == HALT.
- illegal  out  1  one-cycle pulse on an illegal CSR access.

Behaviour:
- Reset (rst low, asynchronous):
  - tohost = RESET_TOHOST; cycle = 0; instret = 0 (both 64-bit).
  - state = RUN; illegal = 0; halted = 0.
- Commit condition: commit = csr_valid & !stall & !flush & legal funct3. funct3 000 or 100 with csr_valid → no commit, no illegal pulse.
- Operand:
  - R-forms: rs1_data.
  - I-forms: zero-extended csr_rs1_idx.
- Write enable:
  - RW/RWI: always write.
  - RS/RC/RSI/RCI: write only if csr_rs1_idx != 0.
- New value:
  - RW: op.
  - RS: old | op.
  - RC: old & ~op.
- Read path (combinational):
  - csr_rdata = current register value before the edge.
  - Address map: 0xC00 cycle[31:0], 0xC80 cycle[63:32], 0xC02 instret[31:0], 0xC82 instret[63:32], TOHOST_ADDR tohost.
  - csr_rdata = 0 for any other address.
- Writes:
  - The tohost update is visible the cycle after commit.
  - Back-to-back CSR instructions: the second reads the first's written value.
  - A write to a counter address, or any access to an unmapped address, raises illegal for exactly one cycle (the cycle after commit) and changes no state.
  - An RS/RC with rs1_idx = 0 to a counter address is a legal read.
- State machine:
  - RUN: cycle += 1 every cycle; instret += inst_retire.
  - RUN → HALT at the edge where a tohost write commits with new value bit0 = 1. tohost takes that value on the same edge.
  - HALT: tohost, cycle and instret are frozen. Further commits are ignored: no write, no illegal pulse. csr_rdata still reads.
  - HALT is left only via rst.
- Counters: 64-bit, wrap 2^64−1 → 0 silently. The edge that enters HALT still increments cycle.
- Simultaneous events:
  - stall and flush both high → no commit.
  - inst_retire with the halting write → instret still increments on that edge.
- Reset asserted mid-instruction → all state returns to reset values immediately; no partial write.

Test Plan:
- Reset then csrrw x0, 0x51e, rs1 = 32'h1 (one cycle, no stall) → tohost = 32'h1 next cycle, halted = 1, cycle frozen at its value at that edge +1.
- csrrwi 0x51e, zimm = 5'd7 → tohost = 32'h7, halted = 1, bench decodes fail test 3. Then csrrw with 32'h0 → tohost stays 32'h7.
- tohost = 32'hF0 via csrrw, then csrrs rs1_idx = 3, data = 32'h0F → csr_rdata = 32'hF0 during the csrrs, tohost = 32'hFF, halted = 1. Then csrrc with rs1_idx = 0 → no write.
- csrrw to 0xC00 with data = 32'h5 → illegal pulses one cycle, cycle unaffected. csrrs x0 on 0xC00 → csr_rdata equals cycle[31:0], no illegal.
- csr_valid held 3 cycles with stall = 1, then 1 cycle released; flush = 1 on a second write → exactly one commit observed; the flushed write leaves tohost unchanged.
- Force cycle to 64'hFFFF_FFFF_FFFF_FFFF → wraps to 0, cycleh reads 0. Assert rst low mid-commit → tohost = 0, halted = 0, asynchronously.

Source files
------------

// File: rtl/csr_tohost_unit.sv
// Zicsr execution unit for tohost (0x51e) and the read-only cycle/instret counters.
// A RUN/HALT machine freezes tohost and the counters once a test reports done via tohost[0].
module csr_tohost_unit #(
  parameter logic [11:0] TOHOST_ADDR  = 12'h51e,
  parameter logic [31:0] RESET_TOHOST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic [2:0]  csr_funct3,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  csr_rs1_idx,
  input  logic [31:0] csr_rs1_data,
  input  logic        inst_retire,
  output logic [31:0] csr_rdata,
  output logic [31:0] tohost,
  output logic        halted,
  output logic        illegal
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 64;

  localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
  localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
  localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
  localparam logic [11:0] ADDR_INSTRETH = 12'hC82;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   tohost_q;
  logic [CNT_W-1:0]  cycle_q;
  logic [CNT_W-1:0]  instret_q;
  logic              illegal_q;

  logic              legal_f3;
  logic              wr_req;
  logic              is_tohost;
  logic              is_counter;
  logic [XLEN-1:0]   operand;
  logic [XLEN-1:0]   tohost_new;
  logic              commit;
  logic              tohost_we;
  logic              illegal_d;
  logic              halt_req;
  logic              cnt_en;

  // Instruction decode: legality, operand source and whether a write is requested.
  always_comb begin
    legal_f3 = 1'b0;
    case (csr_funct3)
      F3_RW, F3_RS, F3_RC, F3_RWI, F3_RSI, F3_RCI: legal_f3 = 1'b1;
      default:                                     legal_f3 = 1'b0;
    endcase
    operand    = csr_funct3[2] ? XLEN'(csr_rs1_idx) : csr_rs1_data;
    wr_req     = (csr_funct3[1:0] == 2'b01) || (csr_rs1_idx != 5'd0);
    is_tohost  = (csr_addr == TOHOST_ADDR);
    is_counter = !is_tohost &&
                 ((csr_addr == ADDR_CYCLE)   || (csr_addr == ADDR_CYCLEH) ||
                  (csr_addr == ADDR_INSTRET) || (csr_addr == ADDR_INSTRETH));
  end

  // Combinational read of the pre-edge register value.
  always_comb begin
    csr_rdata = '0;
    if (is_tohost) begin
      csr_rdata = tohost_q;
    end else begin
      case (csr_addr)
        ADDR_CYCLE:    csr_rdata = cycle_q[31:0];
        ADDR_CYCLEH:   csr_rdata = cycle_q[63:32];
        ADDR_INSTRET:  csr_rdata = instret_q[31:0];
        ADDR_INSTRETH: csr_rdata = instret_q[63:32];
        default:       csr_rdata = '0;
      endcase
    end
  end

  // Read-modify-write value for tohost.
  always_comb begin
    tohost_new = tohost_q;
    case (csr_funct3[1:0])
      2'b01:   tohost_new = operand;
      2'b10:   tohost_new = tohost_q | operand;
      2'b11:   tohost_new = tohost_q & ~operand;
      default: tohost_new = tohost_q;
    endcase
  end

  // Commits are dropped entirely once halted.
  assign commit    = csr_valid && !stall && !flush && legal_f3 && (state_q == RUN);
  assign tohost_we = commit && is_tohost && wr_req;
  assign illegal_d = commit && !is_tohost && (!is_counter || wr_req);
  assign halt_req  = tohost_we && tohost_new[0];

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    case (state_q)
      RUN: begin
        cnt_en = 1'b1;
        if (halt_req) begin
          state_d = HALT;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Architectural registers; the halting edge still counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tohost_q  <= RESET_TOHOST;
      cycle_q   <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
      if (tohost_we) begin
        tohost_q <= tohost_new;
      end
      if (cnt_en) begin
        cycle_q   <= cycle_q + CNT_W'(1);
        instret_q <= instret_q + CNT_W'(inst_retire);
      end
    end
  end

  assign tohost  = tohost_q;
  assign halted  = (state_q == HALT);
  assign illegal = illegal_q;

endmodule

// File: tb/tb_csr_tohost_unit.sv
// Directed self-checking bench for csr_tohost_unit; inputs change and outputs are sampled on negedge.
module tb_csr_tohost_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_valid;
  logic        stall;
  logic        flush;
  logic [2:0]  csr_funct3;
  logic [11:0] csr_addr;
  logic [4:0]  csr_rs1_idx;
  logic [31:0] csr_rs1_data;
  logic        inst_retire;
  logic [31:0] csr_rdata;
  logic [31:0] tohost;
  logic        halted;
  logic        illegal;

  int vectors = 0;
  int errors  = 0;

  csr_tohost_unit dut (
    .clk          (clk),
    .rst          (rst),
    .csr_valid    (csr_valid),
    .stall        (stall),
    .flush        (flush),
    .csr_funct3   (csr_funct3),
    .csr_addr     (csr_addr),
    .csr_rs1_idx  (csr_rs1_idx),
    .csr_rs1_data (csr_rs1_data),
    .inst_retire  (inst_retire),
    .csr_rdata    (csr_rdata),
    .tohost       (tohost),
    .halted       (halted),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle();
    csr_valid    = 1'b0;
    stall        = 1'b0;
    flush        = 1'b0;
    csr_funct3   = 3'b000;
    csr_addr     = 12'h000;
    csr_rs1_idx  = 5'd0;
    csr_rs1_data = 32'h0;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [11:0] a,
                       input logic [4:0] idx, input logic [31:0] d);
    csr_valid    = 1'b1;
    csr_funct3   = f3;
    csr_addr     = a;
    csr_rs1_idx  = idx;
    csr_rs1_data = d;
  endtask

  // Leaves rst high at a negedge with the counters at zero.
  task automatic reset_dut();
    idle();
    inst_retire = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    inst_retire = 1'b0;
    #1;
    vectors++; if (tohost !== 32'h0) begin errors++; $display("FAIL reset_tohost got %h exp %h", tohost, 32'h0); end
    vectors++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
    vectors++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b exp 0", illegal); end
    csr_addr = 12'hC00; #1;
    vectors++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL reset_cycle got %h exp %h", csr_rdata, 32'h0); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_halt_rw();
    reset_dut();
    repeat (3) @(negedge clk);
    drive(3'b001, 12'h51e, 5'd1, 32'h1);
    @(negedge clk);
    idle();
    vectors++; if (tohost !== 32'h1) begin errors++; $display("FAIL halt_rw_tohost got %h exp %h", tohost, 32'h1); end
    vectors++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_rw_halted got %b exp 1", halted); end
    repeat (5) @(negedge clk);
    csr_addr = 12'hC00; #1;
    vectors++; if (csr_rdata !== 32'd4) begin errors++; $display("FAIL halt_rw_cycle_frozen got %h exp %h", csr_rdata, 32'd4); end
    csr_addr = 12'hC80; #1;
    vectors++; if (csr_rdata !== 32'd0) begin errors++; $display("FAIL halt_rw_cycleh got %h exp %h", csr_rdata, 32'd0); end
  endtask

  task automatic test_imm();
    logic [31:0] tnum;
    reset_dut();
    drive(3'b101, 12'h51e, 5'd7, 32'hDEAD_BEEF);
    @(negedge clk);
    tnum = {1'b0, tohost[31:1]};
    vectors++; if (tohost !== 32'h7) begin errors++; $display("FAIL imm_tohost got %h exp %h", tohost, 32'h7); end
    vectors++; if (halted !== 1'b1) begin errors++; $display("FAIL imm_halted got %b exp 1", halted); end
    vectors++; if (tnum !== 32'd3) begin errors++; $display("FAIL imm_testnum got %0d exp 3", tnum); end
    drive(3'b001, 12'h51e, 5'd2, 32'h0);
    @(negedge clk);
    idle();
    vectors++; if (tohost !== 32'h7) begin errors++; $display("FAIL imm_frozen got %h exp %h", tohost, 32'h7); end
    vectors++; if (illegal !== 1'b0) begin errors++; $display("FAIL imm_halt_illegal got %b exp 0", illegal); end
  endtask

  task automatic test_set_clear();
    reset_dut();
    drive(3'b001, 12'h51e, 5'd4, 32'h0000_00FE);
    @(negedge clk);
    vectors++; if (tohost !== 32'hFE) begin errors++; $display("FAIL sc_rw got %h exp %h", tohost, 32'hFE); end
    drive(3'b011, 12'h51e, 5'd5, 32'h0000_000E);
    #1;
    vectors++; if (csr_rdata !== 32'hFE) begin errors++; $display("FAIL sc_rc_rdata got %h exp %h", csr_rdata, 32'hFE); end
    @(negedge clk);
    vectors++; if (tohost !== 32'hF0) begin errors++; $display("FAIL sc_rc got %h exp %h", tohost, 32'hF0); end
    vectors++; if (halted !== 1'b0) begin errors++; $display("FAIL sc_not_halted got %b exp 0", halted); end
    drive(3'b010, 12'h51e, 5'd3, 32'h0000_000F);
    #1;
    vectors++; if (csr_rdata !== 32'hF0) begin errors++; $display("FAIL sc_rs_rdata got %h exp %h", csr_rdata, 32'hF0); end
    @(negedge clk);
    vectors++; if (tohost !== 32'hFF) begin errors++; $display("FAIL sc_rs got %h exp %h", tohost, 32'hFF); end
    vectors++; if (halted !== 1'b1) begin errors++; $display("FAIL sc_rs_halted got %b exp 1", halted); end
    drive(3'b011, 12'h51e, 5'd0, 32'hFFFF_FFFF);
    #1;
    vectors++; if (csr_rdata !== 32'hFF) begin errors++; $display("FAIL sc_rc0_rdata got %h exp %h", csr_rdata, 32'hFF); end
    @(negedge clk);
    idle();
    vectors++; if (tohost !== 32'hFF) begin errors++; $display("FAIL sc_rc0_nowrite got %h exp %h", tohost, 32'hFF); end
  endtask

  task automatic test_illegal();
    reset_dut();
    drive(3'b001, 12'hC00, 5'd1, 32'h5);
    @(negedge clk);
    idle();
    vectors++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_cnt_write got %b exp 1", illegal); end
    csr_addr = 12'hC00; #1;
    vectors++; if (csr_rdata !== 32'd1) begin errors++; $display("FAIL ill_cycle_unaffected got %h exp %h", csr_rdata, 32'd1); end
    @(negedge clk);
    vectors++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_one_cycle got %b exp 0", illegal); end
    drive(3'b010, 12'hC00, 5'd0, 32'hFFFF);
    #1;
    vectors++; if (csr_rdata !== 32'd2) begin errors++; $display("FAIL ill_rs0_rdata got %h exp %h", csr_rdata, 32'd2); end
    @(negedge clk);
    idle();
    vectors++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_rs0_legal got %b exp 0", illegal); end
    drive(3'b110, 12'h123, 5'd0, 32'h0);
    #1;
    vectors++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL ill_unmapped_rdata got %h exp %h", csr_rdata, 32'h0); end
    @(negedge clk);
    vectors++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_unmapped got %b exp 1", illegal); end
    drive(3'b000, 12'h123, 5'd1, 32'h1);
    @(negedge clk);
    idle();
    vectors++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_f3_000 got %b exp 0", illegal); end
    vectors++; if (tohost !== 32'h0) begin errors++; $display("FAIL ill_tohost_untouched got %h exp %h", tohost, 32'h0); end
  endtask

  task automatic test_stall_flush();
    reset_dut();
    drive(3'b001, 12'h51e, 5'd1, 32'h10);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (tohost !== 32'h0) begin errors++; $display("FAIL stall_%0d got %h exp %h", i, tohost, 32'h0); end
    end
    stall = 1'b0;
    @(negedge clk);
    vectors++; if (tohost !== 32'h10) begin errors++; $display("FAIL stall_release got %h exp %h", tohost, 32'h10); end
    drive(3'b001, 12'h51e, 5'd1, 32'h20);
    flush = 1'b1;
    @(negedge clk);
    vectors++; if (tohost !== 32'h10) begin errors++; $display("FAIL flush got %h exp %h", tohost, 32'h10); end
    drive(3'b001, 12'h51e, 5'd1, 32'h30);
    stall = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    idle();
    vectors++; if (tohost !== 32'h10) begin errors++; $display("FAIL stall_flush got %h exp %h", tohost, 32'h10); end
    inst_retire = 1'b1;
    repeat (4) @(negedge clk);
    csr_addr = 12'hC02; #1;
    vectors++; if (csr_rdata !== 32'd4) begin errors++; $display("FAIL instret_count got %h exp %h", csr_rdata, 32'd4); end
    drive(3'b001, 12'h51e, 5'd1, 32'h3);
    @(negedge clk);
    idle();
    vectors++; if (halted !== 1'b1) begin errors++; $display("FAIL instret_halt got %b exp 1", halted); end
    repeat (2) @(negedge clk);
    csr_addr = 12'hC02; #1;
    vectors++; if (csr_rdata !== 32'd5) begin errors++; $display("FAIL instret_halt_edge got %h exp %h", csr_rdata, 32'd5); end
    csr_addr = 12'hC82; #1;
    vectors++; if (csr_rdata !== 32'd0) begin errors++; $display("FAIL instreth got %h exp %h", csr_rdata, 32'd0); end
    inst_retire = 1'b0;
  endtask

  task automatic test_wrap_async_reset();
    reset_dut();
    force dut.cycle_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.cycle_q;
    csr_addr = 12'hC80; #1;
    vectors++; if (csr_rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_pre_hi got %h exp %h", csr_rdata, 32'hFFFF_FFFF); end
    @(negedge clk);
    #1;
    vectors++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL wrap_cycleh got %h exp %h", csr_rdata, 32'h0); end
    csr_addr = 12'hC00; #1;
    vectors++; if (csr_rdata !== 32'h0) begin errors++; $display("FAIL wrap_cycle got %h exp %h", csr_rdata, 32'h0); end
    @(negedge clk);
    drive(3'b001, 12'h51e, 5'd1, 32'h40);
    @(negedge clk);
    vectors++; if (tohost !== 32'h40) begin errors++; $display("FAIL pre_reset_tohost got %h exp %h", tohost, 32'h40); end
    drive(3'b001, 12'h51e, 5'd1, 32'h3);
    #2;
    rst = 1'b0;
    #1;
    vectors++; if (tohost !== 32'h0) begin errors++; $display("FAIL async_rst_tohost got %h exp %h", tohost, 32'h0); end
    vectors++; if (halted !== 1'b0) begin errors++; $display("FAIL async_rst_halted got %b exp 0", halted); end
    @(posedge clk);
    #1;
    vectors++; if (tohost !== 32'h0) begin errors++; $display("FAIL rst_no_partial got %h exp %h", tohost, 32'h0); end
    vectors++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_no_halt got %b exp 0", halted); end
    idle();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_halt_rw();
    test_imm();
    test_set_clear();
    test_illegal();
    test_stall_flush();
    test_wrap_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
